lpc_encoder_param: RTL and testbench

- Parametrised longitudinal-parity (LPC) block encoder. Collects BLOCK_BEATS beats of IN_BYTES bytes from an AXI-Stream-like slave port.
- Emits one code word per block: data bytes + per-byte vertical parity + one horizontal (column) parity byte.
- Sits between the framing front end and the packetiser.
- New over the fixed 2-byte x 4-beat generation: configurable geometry, odd/even parity, early TLAST close with zero padding and byte count, abort flag on TUSER restart, optional output double-buffering.

---
 rtl/lpc_encoder_param.sv | 231 +++++++++++++++++++++++
 tb/tb_lpc_encoder_param.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/lpc_encoder_param.sv
// Parametrised longitudinal-parity block encoder: data bytes + per-byte parity + column parity byte.
// Defining LPC_ENC_DOUBLE_BUF_EN adds an output register so collection overlaps emission.
module lpc_encoder_param #(
  parameter int IN_BYTES    = 2,
  parameter int BLOCK_BEATS = 4,
  parameter bit ODD_PARITY  = 1'b0,
  localparam int BB = IN_BYTES * BLOCK_BEATS,
  localparam int OW = 9 * BB + 8,
  localparam int CW = $clog2(BB + 1)
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [8*IN_BYTES-1:0] TDATA,
  input  logic                  TVALID,
  input  logic                  TLAST,
  input  logic                  TUSER,
  output logic                  TREADY,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [OW-1:0]         OUT_DATA,
  output logic [CW-1:0]         OUT_BYTES,
  output logic                  OUT_LAST,
  output logic                  ABORT
);
  localparam int BCW = $clog2(BLOCK_BEATS + 1);
  localparam logic [BCW-1:0] FULL_BEATS = BCW'(BLOCK_BEATS);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_EMIT    = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  state_t            state_r;
  logic              tready_r;
  logic              out_valid_r;
  logic [OW-1:0]     out_data_r;
  logic [CW-1:0]     out_bytes_r;
  logic              out_last_r;
  logic              abort_r;
  logic [8*BB-1:0]   acc_data_r;
  logic [BB-1:0]     acc_pv_r;
  logic [7:0]        acc_ph_r;
  logic [BCW-1:0]    acc_cnt_r;

  logic              accept_s;
  logic              restart_s;
  logic              close_s;
  logic [BCW-1:0]    base_cnt_s;
  logic [8*BB-1:0]   nxt_data_s;
  logic [BB-1:0]     nxt_pv_s;
  logic [7:0]        nxt_ph_s;
  logic [BCW-1:0]    nxt_cnt_s;
  logic [7:0]        beat_byte_s;
  logic [CW-1:0]     close_bytes_s;
  logic [OW-1:0]     close_word_s;

  function automatic logic [BB-1:0] byte_mask(input logic [CW-1:0] nbytes);
    logic [BB-1:0] m;
    for (int i = 0; i < BB; i++) begin
      m[i] = (i < int'(nbytes)) ? 1'b1 : 1'b0;
    end
    return m;
  endfunction

  // Running parities are kept even; odd mode inverts only bits that belong to received bytes.
  function automatic logic [OW-1:0] make_word(input logic [8*BB-1:0] d, input logic [BB-1:0] pv_even,
                                              input logic [7:0] ph_even, input logic [CW-1:0] nbytes);
    logic [BB-1:0] pv_o;
    logic [7:0]    ph_o;
    pv_o = pv_even ^ (byte_mask(nbytes) & {BB{ODD_PARITY}});
    ph_o = ph_even ^ {8{ODD_PARITY}};
    return {ph_o, pv_o, d};
  endfunction

  function automatic logic [CW-1:0] beats_to_bytes(input logic [BCW-1:0] beats);
    return CW'(int'(beats) * IN_BYTES);
  endfunction

  assign accept_s  = TVALID & tready_r;
  assign restart_s = TUSER & (acc_cnt_r != {BCW{1'b0}});

  // Next accumulator contents if the current beat is accepted
  always_comb begin
    beat_byte_s = 8'h00;
    if (restart_s) begin
      base_cnt_s = {BCW{1'b0}};
      nxt_data_s = {(8*BB){1'b0}};
      nxt_pv_s   = {BB{1'b0}};
      nxt_ph_s   = 8'h00;
    end else begin
      base_cnt_s = acc_cnt_r;
      nxt_data_s = acc_data_r;
      nxt_pv_s   = acc_pv_r;
      nxt_ph_s   = acc_ph_r;
    end
    for (int j = 0; j < IN_BYTES; j++) begin
      beat_byte_s = TDATA[8*(IN_BYTES-j)-1 -: 8];
      nxt_data_s[8*(int'(base_cnt_s)*IN_BYTES + j) +: 8] = beat_byte_s;
      nxt_pv_s[int'(base_cnt_s)*IN_BYTES + j] = ^beat_byte_s;
      nxt_ph_s = nxt_ph_s ^ beat_byte_s;
    end
    nxt_cnt_s     = base_cnt_s + BCW'(1'b1);
    close_s       = TLAST | (nxt_cnt_s == FULL_BEATS);
    close_bytes_s = beats_to_bytes(nxt_cnt_s);
    close_word_s  = make_word(nxt_data_s, nxt_pv_s, nxt_ph_s, close_bytes_s);
  end

`ifdef LPC_ENC_DOUBLE_BUF_EN
  logic              acc_last_r;
  logic [CW-1:0]     hold_bytes_s;
  logic [OW-1:0]     hold_word_s;
  assign hold_bytes_s = beats_to_bytes(acc_cnt_r);
  assign hold_word_s  = make_word(acc_data_r, acc_pv_r, acc_ph_r, hold_bytes_s);
`endif

  // Control FSM, accumulator and registered outputs
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_r     <= ST_COLLECT;
      tready_r    <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= {OW{1'b0}};
      out_bytes_r <= {CW{1'b0}};
      out_last_r  <= 1'b0;
      abort_r     <= 1'b0;
      acc_data_r  <= {(8*BB){1'b0}};
      acc_pv_r    <= {BB{1'b0}};
      acc_ph_r    <= 8'h00;
      acc_cnt_r   <= {BCW{1'b0}};
`ifdef LPC_ENC_DOUBLE_BUF_EN
      acc_last_r  <= 1'b0;
`endif
    end else begin
      abort_r <= 1'b0;
`ifdef LPC_ENC_DOUBLE_BUF_EN
      if (out_valid_r && OUT_READY) begin
        out_valid_r <= 1'b0;
      end
`endif
      case (state_r)
        ST_COLLECT: begin
          tready_r <= 1'b1;
          if (accept_s) begin
            abort_r <= restart_s;
            if (close_s) begin
`ifdef LPC_ENC_DOUBLE_BUF_EN
              if (!out_valid_r || OUT_READY) begin
                out_valid_r <= 1'b1;
                out_data_r  <= close_word_s;
                out_bytes_r <= close_bytes_s;
                out_last_r  <= TLAST;
                acc_data_r  <= {(8*BB){1'b0}};
                acc_pv_r    <= {BB{1'b0}};
                acc_ph_r    <= 8'h00;
                acc_cnt_r   <= {BCW{1'b0}};
              end else begin
                // Output register busy: park the closed block in the accumulator
                acc_data_r  <= nxt_data_s;
                acc_pv_r    <= nxt_pv_s;
                acc_ph_r    <= nxt_ph_s;
                acc_cnt_r   <= nxt_cnt_s;
                acc_last_r  <= TLAST;
                tready_r    <= 1'b0;
                state_r     <= ST_FULL;
              end
`else
              out_valid_r <= 1'b1;
              out_data_r  <= close_word_s;
              out_bytes_r <= close_bytes_s;
              out_last_r  <= TLAST;
              acc_data_r  <= {(8*BB){1'b0}};
              acc_pv_r    <= {BB{1'b0}};
              acc_ph_r    <= 8'h00;
              acc_cnt_r   <= {BCW{1'b0}};
              tready_r    <= 1'b0;
              state_r     <= ST_EMIT;
`endif
            end else begin
              acc_data_r <= nxt_data_s;
              acc_pv_r   <= nxt_pv_s;
              acc_ph_r   <= nxt_ph_s;
              acc_cnt_r  <= nxt_cnt_s;
            end
          end
        end
`ifdef LPC_ENC_DOUBLE_BUF_EN
        ST_FULL: begin
          if (!out_valid_r || OUT_READY) begin
            out_valid_r <= 1'b1;
            out_data_r  <= hold_word_s;
            out_bytes_r <= hold_bytes_s;
            out_last_r  <= acc_last_r;
            acc_data_r  <= {(8*BB){1'b0}};
            acc_pv_r    <= {BB{1'b0}};
            acc_ph_r    <= 8'h00;
            acc_cnt_r   <= {BCW{1'b0}};
            acc_last_r  <= 1'b0;
            tready_r    <= 1'b1;
            state_r     <= ST_COLLECT;
          end else begin
            tready_r    <= 1'b0;
          end
        end
`else
        ST_EMIT: begin
          if (OUT_READY) begin
            out_valid_r <= 1'b0;
            tready_r    <= 1'b1;
            state_r     <= ST_COLLECT;
          end else begin
            tready_r    <= 1'b0;
          end
        end
`endif
        default: begin
          tready_r <= 1'b0;
          state_r  <= ST_COLLECT;
        end
      endcase
    end
  end

  assign TREADY    = tready_r;
  assign OUT_VALID = out_valid_r;
  assign OUT_DATA  = out_data_r;
  assign OUT_BYTES = out_bytes_r;
  assign OUT_LAST  = out_last_r;
  assign ABORT     = abort_r;

endmodule

// File: tb/tb_lpc_encoder_param.sv
// Self-checking bench for lpc_encoder_param: even and odd parity instances share one stimulus stream.
module tb_lpc_encoder_param;
  logic        ACLK;
  logic        ARESET;
  logic [15:0] TDATA;
  logic        TVALID, TLAST, TUSER, OUT_READY;
  logic        TREADY, OUT_VALID, OUT_LAST, ABORT;
  logic [79:0] OUT_DATA;
  logic [3:0]  OUT_BYTES;
  logic        tready_o, out_valid_o, out_last_o, abort_o;
  logic [79:0] out_data_o;
  logic [3:0]  out_bytes_o;

  localparam logic [79:0] FULL_WORD  = 80'hE66B_FF10_0805_0403_0201;
  localparam logic [79:0] FULL_ODD   = 80'h1994_FF10_0805_0403_0201;
  localparam logic [79:0] EARLY_WORD = 80'h040B_0000_0000_0403_0201;
  localparam logic [79:0] EARLY_ODD  = 80'hFB04_0000_0000_0403_0201;
  localparam logic [79:0] ONE_WORD   = 80'hFF00_0000_0000_0000_5AA5;

  int pass_cnt = 0;
  int total_cnt = 0;
  int abort_seen = 0;
  int exp_abort = 0;
  logic [84:0] exp_q[$];
  logic [84:0] exp_odd_q[$];
  logic [84:0] exp_e;
  logic [7:0]  mb [0:7];
  int mbn = 0;
  int mbeats = 0;

  lpc_encoder_param u_dut (
    .ACLK(ACLK), .ARESET(ARESET), .TDATA(TDATA), .TVALID(TVALID), .TLAST(TLAST), .TUSER(TUSER),
    .TREADY(TREADY), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .OUT_BYTES(OUT_BYTES), .OUT_LAST(OUT_LAST), .ABORT(ABORT));

  lpc_encoder_param #(.ODD_PARITY(1'b1)) u_odd (
    .ACLK(ACLK), .ARESET(ARESET), .TDATA(TDATA), .TVALID(TVALID), .TLAST(TLAST), .TUSER(TUSER),
    .TREADY(tready_o), .OUT_VALID(out_valid_o), .OUT_READY(OUT_READY), .OUT_DATA(out_data_o),
    .OUT_BYTES(out_bytes_o), .OUT_LAST(out_last_o), .ABORT(abort_o));

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    total_cnt++;
    assert (got === want) pass_cnt++;
    else begin
      $display("FAIL %s: got %h, expected %h", tag, got, want);
      $error("%s: got %h, expected %h", tag, got, want);
    end
  endtask

  // Reference word built from the received byte list
  function automatic logic [79:0] model_word(input bit odd);
    logic [63:0] d;
    logic [7:0]  pv, ph;
    d = 64'h0; pv = 8'h00; ph = 8'h00;
    for (int i = 0; i < mbn; i++) begin
      d[8*i +: 8] = mb[i];
      pv[i] = (^mb[i]) ^ odd;
      ph = ph ^ mb[i];
    end
    if (odd) ph = ~ph;
    return {ph, pv, d};
  endfunction

  task automatic model_accept(input logic [15:0] d, input bit u, input bit l);
    if (u && mbeats > 0) begin
      mbn = 0; mbeats = 0; exp_abort++;
    end
    mb[mbn] = d[15:8]; mb[mbn+1] = d[7:0];
    mbn += 2; mbeats++;
    if (l || mbeats == 4) begin
      exp_q.push_back({l, 4'(mbn), model_word(1'b0)});
      exp_odd_q.push_back({l, 4'(mbn), model_word(1'b1)});
      mbn = 0; mbeats = 0;
    end
  endtask

  task automatic send_beat(input logic [15:0] d, input bit u, input bit l);
    int n = 0;
    TDATA = d; TUSER = u; TLAST = l; TVALID = 1'b1;
    @(negedge ACLK);
    while (TREADY !== 1'b1 && n < 40) begin
      @(negedge ACLK);
      n++;
    end
    if (TREADY !== 1'b1) begin
      check("tready_timeout", {127'd0, TREADY}, 128'd1);
      TVALID = 1'b0;
    end else begin
      @(posedge ACLK); #1;
      TVALID = 1'b0; TUSER = 1'b0; TLAST = 1'b0;
      model_accept(d, u, l);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((OUT_VALID === 1'b1 || exp_q.size() != 0 || exp_odd_q.size() != 0) && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    if (n >= 50) check("idle_timeout", {127'd0, OUT_VALID}, 128'd0);
    @(posedge ACLK); #1;
  endtask

  // Scoreboard: compare every handshaken word against the queued expectation
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (ABORT === 1'b1) abort_seen++;
      if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
        if (exp_q.size() == 0) check("unexpected_word", {43'd0, OUT_LAST, OUT_BYTES, OUT_DATA}, 128'd0);
        else begin
          exp_e = exp_q.pop_front();
          check("even_word", {43'd0, OUT_LAST, OUT_BYTES, OUT_DATA}, {43'd0, exp_e});
        end
      end
      if (out_valid_o === 1'b1 && OUT_READY === 1'b1) begin
        if (exp_odd_q.size() == 0) check("unexpected_odd", {43'd0, out_last_o, out_bytes_o, out_data_o}, 128'd0);
        else begin
          exp_e = exp_odd_q.pop_front();
          check("odd_word", {43'd0, out_last_o, out_bytes_o, out_data_o}, {43'd0, exp_e});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET = 1'b1; TDATA = 16'h0; TVALID = 1'b0; TLAST = 1'b0; TUSER = 1'b0; OUT_READY = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_tready", {127'd0, TREADY}, 128'd0);
    check("rst_out_valid", {127'd0, OUT_VALID}, 128'd0);
    check("rst_out_data", {48'd0, OUT_DATA}, 128'd0);
    check("rst_out_bytes", {124'd0, OUT_BYTES}, 128'd0);
    check("rst_out_last_abort", {126'd0, OUT_LAST, ABORT}, 128'd0);
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    check("tready_after_reset", {127'd0, TREADY}, 128'd1);

    // Full block, even and odd parity
    send_beat(16'h0102, 1'b1, 1'b0);
    send_beat(16'h0304, 1'b0, 1'b0);
    send_beat(16'h0508, 1'b0, 1'b0);
    send_beat(16'h10FF, 1'b0, 1'b0);
    check("full_valid", {127'd0, OUT_VALID}, 128'd1);
    check("full_data", {48'd0, OUT_DATA}, {48'd0, FULL_WORD});
    check("full_bytes_last", {123'd0, OUT_BYTES, OUT_LAST}, {123'd0, 4'd8, 1'b0});
    check("full_odd_data", {48'd0, out_data_o}, {48'd0, FULL_ODD});
    wait_idle();

    // Early close with zero padding
    send_beat(16'h0102, 1'b1, 1'b0);
    send_beat(16'h0304, 1'b0, 1'b1);
    check("early_data", {48'd0, OUT_DATA}, {48'd0, EARLY_WORD});
    check("early_bytes_last", {123'd0, OUT_BYTES, OUT_LAST}, {123'd0, 4'd4, 1'b1});
    check("early_odd_data", {48'd0, out_data_o}, {48'd0, EARLY_ODD});
    wait_idle();

    // Single-beat block: TUSER and TLAST together
    send_beat(16'hA55A, 1'b1, 1'b1);
    check("single_data", {48'd0, OUT_DATA}, {48'd0, ONE_WORD});
    check("single_bytes_last", {123'd0, OUT_BYTES, OUT_LAST}, {123'd0, 4'd2, 1'b1});
    wait_idle();

    // Abort: restart mid-block
    send_beat(16'h0102, 1'b1, 1'b0);
    send_beat(16'hAAAA, 1'b0, 1'b0);
    send_beat(16'h0102, 1'b1, 1'b0);
    check("abort_pulse", {127'd0, ABORT}, 128'd1);
    send_beat(16'h0304, 1'b0, 1'b0);
    check("abort_cleared", {127'd0, ABORT}, 128'd0);
    send_beat(16'h0508, 1'b0, 1'b0);
    send_beat(16'h10FF, 1'b0, 1'b0);
    check("abort_word", {48'd0, OUT_DATA}, {48'd0, FULL_WORD});
    wait_idle();

    // Backpressure
    OUT_READY = 1'b0;
    send_beat(16'h0102, 1'b1, 1'b0);
    send_beat(16'h0304, 1'b0, 1'b0);
    send_beat(16'h0508, 1'b0, 1'b0);
    send_beat(16'h10FF, 1'b0, 1'b0);
`ifdef LPC_ENC_DOUBLE_BUF_EN
    send_beat(16'h1122, 1'b1, 1'b0);
    send_beat(16'h3344, 1'b0, 1'b0);
    send_beat(16'h5566, 1'b0, 1'b0);
    @(negedge ACLK);
    check("db_tready_open", {127'd0, TREADY}, 128'd1);
    send_beat(16'h7788, 1'b0, 1'b0);
    @(negedge ACLK);
    check("db_tready_full", {127'd0, TREADY}, 128'd0);
    check("db_hold_data", {48'd0, OUT_DATA}, {48'd0, FULL_WORD});
`else
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      check("bp_valid", {127'd0, OUT_VALID}, 128'd1);
      check("bp_hold_data", {48'd0, OUT_DATA}, {48'd0, FULL_WORD});
      check("bp_tready", {127'd0, TREADY}, 128'd0);
    end
`endif
    @(posedge ACLK); #1;
    OUT_READY = 1'b1;
    wait_idle();

    // Reset mid-block discards the partial block
    send_beat(16'h0102, 1'b1, 1'b0);
    send_beat(16'h0304, 1'b0, 1'b0);
    ARESET = 1'b1;
    mbn = 0; mbeats = 0;
    @(posedge ACLK); #1;
    check("midrst_valid_tready", {126'd0, OUT_VALID, TREADY}, 128'd0);
    ARESET = 1'b0;
    send_beat(16'hDEAD, 1'b1, 1'b0);
    send_beat(16'hBEEF, 1'b0, 1'b0);
    send_beat(16'h0000, 1'b0, 1'b0);
    send_beat(16'h8001, 1'b0, 1'b0);
    wait_idle();

    check("queues_drained", 128'(exp_q.size() + exp_odd_q.size()), 128'd0);
    check("abort_count", 128'(abort_seen), 128'(exp_abort));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
